// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared FSM state encoding and I2C field widths for the bus arbiter.
package i2c_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin winner select, searching upward from last+1.
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // Walk from lowest to highest priority so the closest requester after last wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(last) + k) % N]) begin
        gnt = N'(1) << ((int'(last) + k) % N);
        idx = IW'((int'(last) + k) % N);
      end
  end
endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one byte-level I2C master among N_REQ requesters (WAIT watchdog with I2C_ARB_TIMEOUT_EN).
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0]             req_rw,
  input  logic [I2C_ADDR_W*N_REQ-1:0]  req_addr,
  input  logic [I2C_DATA_W*N_REQ-1:0]  req_wdata,
  output logic [N_REQ-1:0]             grant,
  output logic [N_REQ-1:0]             req_done,
  output logic                         req_err,
  output logic [I2C_DATA_W-1:0]        rsp_rdata,
  output logic                         m_start,
  output logic                         m_rw,
  output logic [I2C_ADDR_W-1:0]        m_addr,
  output logic [I2C_DATA_W-1:0]        m_wdata,
  input  logic                         m_busy,
  input  logic                         m_done,
  input  logic                         m_nack,
  input  logic [I2C_DATA_W-1:0]        m_rdata,
  output logic                         m_abort
);
  localparam int IW = $clog2(N_REQ);
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("i2c_bus_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC at least 2");
  end
  state_t state, nxt;
  logic [N_REQ-1:0] win;
  logic [IW-1:0] win_idx, gidx, last_grant;
  logic done_ev, expire;
  rr_arbiter #(.N(N_REQ)) u_rr (
    .req (req_valid),
    .last(last_grant),
    .gnt (win),
    .idx (win_idx)
  );
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tcnt    <= '0;
      m_abort <= 1'b0;
    end else begin
      tcnt    <= state == WAIT ? tcnt + 1'b1 : '0;
      m_abort <= expire;
    end
`else
  assign m_abort = 1'b0;
`endif
  always_comb begin
    done_ev = state == WAIT && m_done;
`ifdef I2C_ARB_TIMEOUT_EN
    expire = state == WAIT && !m_done && tcnt == TW'(TIMEOUT_CYC - 1);
`else
    expire = 1'b0;
`endif
    nxt = state == IDLE  ? (|req_valid ? ISSUE : IDLE) :
          state == ISSUE ? (!m_busy ? WAIT : ISSUE) :
          state == WAIT  ? (done_ev || expire ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      gidx       <= '0;
      last_grant <= IW'(N_REQ - 1);
      req_done   <= '0;
      req_err    <= 1'b0;
      rsp_rdata  <= '0;
      m_start    <= 1'b0;
      m_rw       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      state   <= nxt;
      m_start <= state == ISSUE && !m_busy;
      if (state == IDLE && |req_valid) begin
        grant   <= win;
        gidx    <= win_idx;
        m_rw    <= req_rw[win_idx];
        m_addr  <= req_addr[int'(win_idx) * I2C_ADDR_W +: I2C_ADDR_W];
        m_wdata <= req_wdata[int'(win_idx) * I2C_DATA_W +: I2C_DATA_W];
      end
      // A timeout completes the transaction as an error and keeps the old read byte.
      if (done_ev || expire) begin
        req_done <= grant;
        req_err  <= m_done ? m_nack : 1'b1;
        if (done_ev && m_rw) rsp_rdata <= m_rdata;
      end
      if (state == RESP) begin
        req_done   <= '0;
        req_err    <= 1'b0;
        grant      <= '0;
        last_grant <= gidx;
      end
    end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: directed table-driven bench for i2c_bus_arbiter plus round-robin, busy, reset and watchdog sequences.
module tb_i2c_bus_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] req_valid = '0, req_rw = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0] grant, req_done;
  logic req_err, m_start, m_rw, m_abort;
  logic [7:0] rsp_rdata, m_wdata;
  logic [6:0] m_addr;
  logic m_busy = 1'b0, m_done = 1'b0, m_nack = 1'b0;
  logic [7:0] m_rdata = '0;
  int n_chk = 0, n_fail = 0;

  i2c_bus_arbiter #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .req_done(req_done),
    .req_err(req_err), .rsp_rdata(rsp_rdata), .m_start(m_start), .m_rw(m_rw),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done),
    .m_nack(m_nack), .m_rdata(m_rdata), .m_abort(m_abort)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  typedef struct {
    int idx; logic rw; logic [6:0] addr; logic [7:0] wdata;
    logic nack; logic [7:0] rdata; int busy;
    logic [3:0] exp_grant; logic exp_err; logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_req_done"}, req_done, 0);
    chk({tag, "_req_err"}, req_err, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_m_start"}, m_start, 0);
    chk({tag, "_m_cmd"}, {m_rw, m_addr, m_wdata}, 0);
    chk({tag, "_m_abort"}, m_abort, 0);
  endtask

  // Raise one request, check the grant after one edge, then wait for m_start and return its latency.
  task automatic issue(input int idx, input logic rw, input logic [6:0] a, input logic [7:0] d,
                       input int busy, input logic [3:0] exp_g, output int lat);
    req_valid[idx] = 1'b1;
    req_rw[idx] = rw;
    req_addr[7*idx +: 7] = a;
    req_wdata[8*idx +: 8] = d;
    m_busy = busy > 0;
    tick();
    chk("grant", grant, exp_g);
    chk("start_early", m_start, 0);
    lat = 0;
    while (!m_start && lat < 40) begin
      tick();
      lat++;
      if (lat == busy) m_busy = 1'b0;
    end
    m_busy = 1'b0;
    chk("m_cmd_at_start", {m_rw, m_addr, m_wdata}, {rw, a, d});
  endtask

  task automatic pulse_done(input logic nack, input logic [7:0] rd);
    m_done = 1'b1;
    m_nack = nack;
    m_rdata = rd;
    tick();
    m_done = 1'b0;
    m_nack = 1'b0;
  endtask

  initial begin
    int lat, cnt;
    logic [7:0] held;
    vecs[0] = '{0, 1'b0, 7'h55, 8'hAA, 1'b0, 8'hEE, 0, 4'b0001, 1'b0, 8'h00};
    vecs[1] = '{2, 1'b1, 7'h55, 8'h00, 1'b0, 8'h3C, 0, 4'b0100, 1'b0, 8'h3C};
    vecs[2] = '{1, 1'b0, 7'h22, 8'h5A, 1'b1, 8'h99, 0, 4'b0010, 1'b1, 8'h3C};
    vecs[3] = '{3, 1'b1, 7'h7F, 8'h11, 1'b0, 8'hC3, 10, 4'b1000, 1'b0, 8'hC3};
    vecs[4] = '{0, 1'b0, 7'h01, 8'hFF, 1'b0, 8'h77, 2, 4'b0001, 1'b0, 8'hC3};
    repeat (3) tick();
    chk_reset_outputs("reset");
    reset = 1'b1;
    tick();
    m_done = 1'b1;
    tick();
    m_done = 1'b0;
    chk("done_in_idle_ignored", {req_done, req_err}, 0);

    foreach (vecs[i]) begin
      issue(vecs[i].idx, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].busy, vecs[i].exp_grant, lat);
      chk("start_latency", lat, vecs[i].busy + 1);
      tick();
      chk("start_once", m_start, 0);
      tick();
      chk("no_early_done", req_done, 0);
      pulse_done(vecs[i].nack, vecs[i].rdata);
      chk("req_done", req_done, vecs[i].exp_grant);
      chk("req_err", req_err, vecs[i].exp_err);
      chk("rsp_rdata", rsp_rdata, vecs[i].exp_rd);
      req_valid = '0;
      tick();
      chk("done_cleared", {req_done, req_err}, 0);
      chk("grant_cleared", grant, 0);
      chk("cmd_held", {m_rw, m_addr, m_wdata}, {vecs[i].rw, vecs[i].addr, vecs[i].wdata});
    end

    // Round robin with every requester held from reset.
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1;
      req_rw[i] = 1'b0;
      req_addr[7*i +: 7] = 7'(8'h10 + i);
      req_wdata[8*i +: 8] = 8'(8'hA0 + i);
    end
    tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cnt = 0;
      while (grant == 0 && cnt < 10) begin
        tick();
        cnt++;
      end
      chk("rr_grant", grant, 4'b0001 << (k % 4));
      chk("rr_addr", m_addr, 7'(8'h10 + k % 4));
      cnt = 0;
      while (!m_start && cnt < 10) begin
        tick();
        cnt++;
      end
      pulse_done(1'b0, 8'h00);
      chk("rr_done", req_done, 4'b0001 << (k % 4));
      tick();
    end
    req_valid = '0;
    tick();
    tick();

    held = rsp_rdata;
`ifdef I2C_ARB_TIMEOUT_EN
    issue(1, 1'b1, 7'h44, 8'h00, 0, 4'b0010, lat);
    cnt = 0;
    while (!m_abort && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("timeout_cycles", cnt, 16);
    chk("timeout_done", req_done, 4'b0010);
    chk("timeout_err", req_err, 1);
    chk("timeout_rdata", rsp_rdata, held);
    req_valid = '0;
    tick();
    chk("abort_pulse", m_abort, 0);
    tick();
    issue(1, 1'b1, 7'h45, 8'h00, 0, 4'b0010, lat);
    repeat (15) tick();
    pulse_done(1'b0, 8'h5E);
    chk("expiry_done_wins", req_done, 4'b0010);
    chk("expiry_err", req_err, 0);
    chk("expiry_no_abort", m_abort, 0);
    chk("expiry_rdata", rsp_rdata, 8'h5E);
    req_valid = '0;
    tick();
    chk("expiry_no_abort_late", m_abort, 0);
    tick();
`else
    issue(1, 1'b1, 7'h44, 8'h00, 0, 4'b0010, lat);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (m_abort || req_done != 0) cnt++;
    end
    chk("wait_persists", cnt, 0);
    pulse_done(1'b1, 8'h5E);
    chk("late_done", req_done, 4'b0010);
    chk("late_err", req_err, 1);
    chk("late_rdata", rsp_rdata, 8'h5E);
    req_valid = '0;
    tick();
    tick();
`endif

    // Asynchronous reset while waiting on the engine.
    issue(2, 1'b1, 7'h33, 8'h44, 0, 4'b0100, lat);
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs("mid_wait");
    req_valid = '0;
    tick();
    reset = 1'b1;
    tick();
    chk("post_reset_idle", grant, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
